soc_obi_to_apb: RTL and testbench

SOC_OBI_TO_APB -- requirements
Module: soc_obi_to_apb

---
 rtl/soc_obi_to_apb.sv | 236 +++++++++++++++++++++++
 tb/tb_soc_obi_to_apb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_obi_to_apb.sv
// soc_obi_to_apb_pkg / soc_obi_to_apb
//
// Bridges one 64-bit OBI manager transaction at a time onto a 32-bit APB
// completer. Each OBI access is split into at most two APB transfers:
// the lower word first, then the upper word. Byte enables pick the halves.
// Read data is assembled into a 64-bit response, and APB errors are ORed
// into a sticky error flag.
//
// Optional feature (macro SOC_OBI2APB_TIMEOUT_EN): an ACCESS-phase watchdog.
// An APB half that waits TimeoutCycles cycles without pready is ended with
// an error and zero read data. When the macro is undefined there is no
// counter, and ACCESS waits for pready indefinitely.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   obi_req_i    OBI request (req, addr[47:0], we, be[7:0], wdata[63:0], aid[3:0])
//   obi_rsp_o    OBI response (gnt, rvalid, rdata[63:0], rid[3:0], err)
//   apb_req_o    APB request (paddr, pprot, psel, penable, pwrite, pwdata, pstrb)
//   apb_rsp_i    APB response (pready, prdata, pslverr)
//   dbg_state_o  current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
//
// Handshake: an OBI request is accepted in the cycle where req && gnt.
// gnt is offered only in IDLE, so at most one transaction is in flight.
// The response is a one-cycle rvalid pulse with no back-pressure. An APB
// transfer completes in the ACCESS cycle where pready is high.

package soc_obi_to_apb_pkg;
    typedef struct packed {
        logic        req;
        logic [47:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [3:0]  aid;
    } soc_obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [63:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } soc_obi_rsp_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } soc_apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } soc_apb_resp_t;
endpackage

module soc_obi_to_apb
    import soc_obi_to_apb_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  soc_obi_req_t  obi_req_i,
    output soc_obi_rsp_t  obi_rsp_o,
    output soc_apb_req_t  apb_req_o,
    input  soc_apb_resp_t apb_rsp_i,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e       state_q;
    logic [28:0]  addr_q;       // addr[31:3]; the word offset comes from the half
    logic         we_q;
    logic [7:0]   be_q;
    logic [63:0]  wdata_q;
    logic [3:0]   aid_q;
    logic         upper_q;      // half currently on the bus is the upper word
    logic         upper_pend_q; // upper word still to be issued after this one
    soc_apb_req_t apb_q;
    logic         rvalid_q;
    logic [63:0]  rdata_q;
    logic         err_q;

    logic         gnt;
    logic         grant_upper;  // only the upper half is enabled
    logic         grant_both;
    logic         timeout;
    logic         half_done;
    logic [31:0]  half_rdata;
    logic         half_err;

    // Build the SETUP-phase request for one half. Reads drive zero data and
    // strobes. be == 0 still issues the lower half, with pstrb = 0.
    function automatic soc_apb_req_t half_req(input logic [28:0] a,
                                              input logic        we,
                                              input logic [7:0]  be,
                                              input logic [63:0] wd,
                                              input logic        upper);
        soc_apb_req_t r;
        r         = '0;
        r.psel    = 1'b1;
        r.pwrite  = we;
        r.paddr   = {a, upper, 2'b00};
        if (we) begin
            r.pwdata = upper ? wd[63:32] : wd[31:0];
            r.pstrb  = upper ? be[7:4]   : be[3:0];
        end
        return r;
    endfunction

    assign gnt         = rst_ni && (state_q == IDLE) && obi_req_i.req;
    assign grant_upper = (obi_req_i.be[3:0] == 4'h0) && (obi_req_i.be[7:4] != 4'h0);
    assign grant_both  = (obi_req_i.be[3:0] != 4'h0) && (obi_req_i.be[7:4] != 4'h0);

`ifdef SOC_OBI2APB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] to_cnt_q;

    // Held at zero outside ACCESS, so every SETUP entry starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q != ACCESS) begin
            to_cnt_q <= '0;
        end else if (!apb_rsp_i.pready) begin
            to_cnt_q <= to_cnt_q + CntW'(1);
        end
    end

    // Fires on the TimeoutCycles-th ACCESS cycle without pready.
    assign timeout = (state_q == ACCESS) && !apb_rsp_i.pready &&
                     (to_cnt_q == CntW'(TimeoutCycles - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign timeout            = 1'b0;
`endif

    assign half_done  = apb_rsp_i.pready || timeout;
    assign half_rdata = timeout ? 32'h0 : apb_rsp_i.prdata;
    assign half_err   = apb_rsp_i.pslverr || timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            aid_q        <= '0;
            upper_q      <= 1'b0;
            upper_pend_q <= 1'b0;
            apb_q        <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt) begin
                        addr_q       <= obi_req_i.addr[31:3];
                        we_q         <= obi_req_i.we;
                        be_q         <= obi_req_i.be;
                        wdata_q      <= obi_req_i.wdata;
                        aid_q        <= obi_req_i.aid;
                        upper_q      <= grant_upper;
                        upper_pend_q <= grant_both;
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                        apb_q        <= half_req(obi_req_i.addr[31:3], obi_req_i.we,
                                                 obi_req_i.be, obi_req_i.wdata,
                                                 grant_upper);
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    apb_q.penable <= 1'b1;
                    state_q       <= ACCESS;
                end
                ACCESS: begin
                    if (half_done) begin
                        if (upper_q) rdata_q[63:32] <= half_rdata;
                        else         rdata_q[31:0]  <= half_rdata;
                        err_q <= err_q | half_err;
                        // An error on the lower half does not cancel the upper half.
                        if (upper_pend_q) begin
                            upper_pend_q <= 1'b0;
                            upper_q      <= 1'b1;
                            apb_q        <= half_req(addr_q, we_q, be_q, wdata_q, 1'b1);
                            state_q      <= SETUP;
                        end else begin
                            apb_q    <= '0;
                            rvalid_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The bridge only forwards the 8-byte-aligned low 32 address bits.
    logic unused_addr;
    assign unused_addr = ^{obi_req_i.addr[47:32], obi_req_i.addr[2:0]};

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = gnt;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.rid    = aid_q;
        obi_rsp_o.err    = err_q;
    end

    assign apb_req_o   = apb_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_soc_obi_to_apb.sv
// tb_soc_obi_to_apb
//
// Bench for soc_obi_to_apb. An OBI driver task pushes the expected APB
// transfers and the expected OBI response. An APB completer model answers
// with configurable wait states, read data and errors, and pops the
// expected transfers. A response monitor pops the expected OBI responses.

module tb_soc_obi_to_apb;
    import soc_obi_to_apb_pkg::*;

    localparam int ToCycles = 8;

    logic          clk;
    logic          rst_n;
    soc_obi_req_t  obi_req;
    soc_obi_rsp_t  obi_rsp;
    soc_apb_req_t  apb_req;
    soc_apb_resp_t apb_rsp;
    logic [1:0]    dbg_state;

    soc_obi_to_apb #(.TimeoutCycles(ToCycles)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .obi_req_i   (obi_req),
        .obi_rsp_o   (obi_rsp),
        .apb_req_o   (apb_req),
        .apb_rsp_i   (apb_rsp),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [68:0] exp_q[$];      // {err, rid, rdata}
    logic [68:0] apb_exp_q[$];  // {pwrite, paddr, pwdata, pstrb}
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- APB completer model ----------------
    int           wait_cfg = 0;
    logic [31:0]  rd_lo = '0, rd_hi = '0;
    logic         err_lo = 1'b0, err_hi = 1'b0;
    int           acc_cnt = 0;
    soc_apb_req_t held;

    initial apb_rsp = '0;

    always @(negedge clk) begin
        if (rst_n && apb_req.psel && apb_req.penable) begin
            if (acc_cnt == 0) held = apb_req;
            else check("apb_stable", 128'(apb_req), 128'(held));
            check("gnt_busy", 128'(obi_rsp.gnt), 128'(0));
            if (acc_cnt >= wait_cfg) begin
                apb_rsp.pready  = 1'b1;
                apb_rsp.prdata  = apb_req.paddr[2] ? rd_hi : rd_lo;
                apb_rsp.pslverr = apb_req.paddr[2] ? err_hi : err_lo;
                if (apb_exp_q.size() == 0) begin
                    check("apb_unexpected", 128'(1), 128'(0));
                end else begin
                    check("apb_xfer", 128'({apb_req.pwrite, apb_req.paddr, apb_req.pwdata,
                                            apb_req.pstrb}), 128'(apb_exp_q.pop_front()));
                    check("pprot", 128'(apb_req.pprot), 128'(0));
                end
            end else begin
                apb_rsp.pready = 1'b0;
            end
            acc_cnt++;
        end else begin
            apb_rsp = '0;
            acc_cnt = 0;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && obi_rsp.rvalid) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 128'(1), 128'(0));
            else check("rsp", 128'({obi_rsp.err, obi_rsp.rid, obi_rsp.rdata}),
                       128'(exp_q.pop_front()));
            check("idle_psel", 128'({apb_req.psel, apb_req.penable}), 128'(0));
        end
    end

    // ---------------- OBI driver ----------------
    task automatic obi_txn(input logic [47:0] addr, input logic we, input logic [7:0] be,
                           input logic [63:0] wdata, input logic [3:0] aid,
                           input int exp_lat, input logic to);
        logic        lo, hi, e;
        logic [63:0] rd;
        int          cyc;
        logic        got;
        lo = (be[3:0] != 4'h0) || (be == 8'h00);
        hi = (be[7:4] != 4'h0);
        rd = '0;
        e  = 1'b0;
        if (lo) begin
            if (!to) apb_exp_q.push_back({we, addr[31:3], 3'b000,
                                          we ? wdata[31:0] : 32'h0, we ? be[3:0] : 4'h0});
            rd[31:0] = to ? 32'h0 : rd_lo;
            e = e | err_lo | to;
        end
        if (hi) begin
            if (!to) apb_exp_q.push_back({we, addr[31:3], 3'b100,
                                          we ? wdata[63:32] : 32'h0, we ? be[7:4] : 4'h0});
            rd[63:32] = to ? 32'h0 : rd_hi;
            e = e | err_hi | to;
        end
        exp_q.push_back({e, aid, rd});

        @(posedge clk); #1;
        obi_req.req   = 1'b1;
        obi_req.addr  = addr;
        obi_req.we    = we;
        obi_req.be    = be;
        obi_req.wdata = wdata;
        obi_req.aid   = aid;
        @(negedge clk);
        check("gnt", 128'(obi_rsp.gnt), 128'(1));
        @(posedge clk); #1;
        obi_req = '0;

        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (obi_rsp.rvalid) begin
                got = 1'b1;
                check("resp_gnt", 128'(obi_rsp.gnt), 128'(0));
            end
        end
        check("rvalid_seen", 128'(got), 128'(1));
        if (got) check("latency", 128'(cyc), 128'(exp_lat));
        @(negedge clk);
        check("rvalid_single", 128'(obi_rsp.rvalid), 128'(0));
    endtask

    // ---------------- stimulus ----------------
    localparam int HoldCycles =
`ifdef SOC_OBI2APB_TIMEOUT_EN
        4;
`else
        20;
`endif

    initial begin
        logic [7:0]  be;
        logic        we;
        logic [47:0] addr;
        logic [63:0] wd;
        int          nh;
        int          cyc;

        obi_req = '0;
        rst_n   = 1'b0;
        obi_req.req = 1'b1;   // grant must stay low while in reset
        repeat (2) @(negedge clk);
        check("rst_gnt", 128'(obi_rsp.gnt), 128'(0));
        check("rst_apb", 128'(apb_req), 128'(0));
        check("rst_rsp", 128'({obi_rsp.rvalid, obi_rsp.err, obi_rsp.rdata, obi_rsp.rid}), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(0));
        obi_req = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two-half read with immediate pready.
        rd_lo = 32'h1111_1111; rd_hi = 32'h2222_2222;
        obi_txn(48'h0000_1000, 1'b0, 8'hFF, 64'h0, 4'h3, 5, 1'b0);

        // Upper-only write.
        obi_txn(48'h0000_0020, 1'b1, 8'hF0, 64'hAABB_CCDD_0000_0000, 4'h1, 3, 1'b0);

        // Error on the lower half; the upper half is still issued.
        err_lo = 1'b1;
        obi_txn(48'h0000_0300, 1'b0, 8'hFF, 64'h0, 4'hA, 5, 1'b0);
        err_lo = 1'b0;

        // Three wait states on a lower-only write.
        wait_cfg = 3;
        obi_txn(48'h0000_0408, 1'b1, 8'h0F, 64'h0123_4567_89AB_CDEF, 4'h7, 6, 1'b0);
        wait_cfg = 0;

        // be == 0 issues the lower half with zero strobe; high/low addr bits dropped.
        obi_txn(48'hBEEF_0000_0505, 1'b1, 8'h00, 64'hFFFF_FFFF_5555_AAAA, 4'h2, 3, 1'b0);
        rd_lo = 32'hCAFE_0001; rd_hi = 32'hCAFE_0002;
        obi_txn(48'h0000_0600, 1'b0, 8'h30, 64'h0, 4'h9, 3, 1'b0);
        obi_txn(48'h0000_0700, 1'b0, 8'h01, 64'h0, 4'hC, 3, 1'b0);

        // Random mix.
        for (int i = 0; i < 12; i++) begin
            be       = 8'($urandom_range(0, 255));
            we       = 1'($urandom_range(0, 1));
            addr     = {16'($urandom), 32'($urandom)};
            wd       = {32'($urandom), 32'($urandom)};
            rd_lo    = 32'($urandom);
            rd_hi    = 32'($urandom);
            err_lo   = 1'($urandom_range(0, 1));
            err_hi   = 1'($urandom_range(0, 1));
            wait_cfg = $urandom_range(0, 2);
            nh       = ((be[3:0] != 4'h0) || (be == 8'h00) ? 1 : 0) + (be[7:4] != 4'h0 ? 1 : 0);
            obi_txn(addr, we, be, wd, 4'(i), 1 + nh * (2 + wait_cfg), 1'b0);
        end
        err_lo = 1'b0; err_hi = 1'b0;

        // Completer that never answers.
        wait_cfg = 1000000;
`ifdef SOC_OBI2APB_TIMEOUT_EN
        obi_txn(48'h0000_0040, 1'b0, 8'h0F, 64'h0, 4'h5, 3 + ToCycles - 1, 1'b1);
`endif

        // Reset during ACCESS: transaction dropped, no response.
        @(posedge clk); #1;
        obi_req.req  = 1'b1;
        obi_req.addr = 48'h80;
        obi_req.be   = 8'h0F;
        obi_req.aid  = 4'h6;
        @(negedge clk);
        check("gnt2", 128'(obi_rsp.gnt), 128'(1));
        cyc = 0;
        while (!(apb_req.psel && apb_req.penable) && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_access", 128'(apb_req.psel && apb_req.penable), 128'(1));
        repeat (HoldCycles) @(negedge clk);
        check("stuck_access", 128'({dbg_state, apb_req.psel, apb_req.penable}),
              128'({2'd2, 1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("rst_psel", 128'({apb_req.psel, apb_req.penable}), 128'(0));
        check("rst_gnt2", 128'(obi_rsp.gnt), 128'(0));
        check("rst_rvalid", 128'(obi_rsp.rvalid), 128'(0));
        obi_req  = '0;
        wait_cfg = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_state", 128'(dbg_state), 128'(0));

        // Normal service after the reset.
        rd_lo = 32'h600D_0000; rd_hi = 32'h600D_0004;
        obi_txn(48'h0000_0900, 1'b0, 8'hFF, 64'h0, 4'hE, 5, 1'b0);

        repeat (3) @(negedge clk);
        check("rsp_q_empty", 128'(exp_q.size()), 128'(0));
        check("apb_q_empty", 128'(apb_exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Overall watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
